kf_dt_param_gen: RTL
====================

# kf_dt_param_gen

- Upstream stage of the covariance-prediction CMU array.
- Takes a new sample interval Δt (IEEE-754 binary64) on a start handshake and produces the time coefficients every CMU channel consumes: Δt, ½·Δt² and ⅙·Δt³.
- Computes them with one shared `fp_multiplier`, sequenced by an FSM.
- Publishes the three values atomically from shadow registers, so downstream CMUs never see a mixed old/new set.

## Interface
- `DBL_WIDTH`, 64, operand width (binary64 only).
- `HALF_CONST`, 64'h3FE0000000000000, 0.5.
- `SIXTH_CONST`, 64'h3FC5555555555555, 1/6 (round-to-nearest).
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request to compute a new set; accepted when `ready`=1.
- `dt_in`  in  64  new Δt; sampled on the accepted `start` cycle.
- `ready`  out  1  high in IDLE.
- `delta_t`  out  64  published Δt.
- `half_dt2`  out  64  published ½·Δt².
- `sixth_dt3`  out  64  published ⅙·Δt³.
- `params_valid`  out  1  level; published set is valid.
- `update_pulse`  out  1  one-cycle pulse on the cycle a new set is published.
- `err_pulse`  out  1  one-cycle pulse when a start is rejected.

## Operation
- **States:** IDLE → MUL_DT2 → MUL_HALF → MUL_DT3 → MUL_SIXTH → COMMIT → IDLE.
- **IDLE, start accepted:**
  - `start`=1 with valid `dt_in` latches `dt_in` into `dt_r` and moves to MUL_DT2.
  - `start` outside IDLE is ignored; it is not queued.
- **Rejection:**
  - `dt_in` is rejected if sign=1 or exponent=11'h7FF (negative, Inf, NaN).
  - A rejected start stays in IDLE and pulses `err_pulse` the next cycle.
  - Published outputs and `params_valid` are unchanged.
  - +0.0 and subnormals are accepted.
- **Operation sequence:**
  - MUL_DT2: dt2_r = dt_r·dt_r.
  - MUL_HALF: half_r = dt2_r·HALF_CONST.
  - MUL_DT3: dt3_r = dt2_r·dt_r.
  - MUL_SIXTH: sixth_r = dt3_r·SIXTH_CONST.
- **Multiplier handshake, per operation:**
  - Drive operands, hold multiplier `valid`=1 and hold operands stable until `finish`=1 is sampled.
  - Capture `result` on that same edge.
  - Drive `valid`=0 for exactly one gap cycle, then enter the next state.
- **COMMIT (one cycle):**
  - Copy `dt_r`, `half_r` and `sixth_r` to the published registers.
  - Set `params_valid`=1 and pulse `update_pulse`.
  - Return to IDLE.
- **Published outputs during computation:** outputs hold the previous set and `params_valid` stays at its previous value. A valid old set is never withdrawn.
- **Arithmetic:** no local arithmetic; all products use `fp_multiplier` rounding.

## Timing
- **Reset values:**
  - All published outputs 0 and `params_valid`=0.
  - `update_pulse`=0, `err_pulse`=0, `ready`=1.
  - Multiplier `valid`=0 and FSM in IDLE.
- **Latency** (L = cycles from multiplier `valid` rise to `finish` sampled):
  - Start accepted at edge T.
  - Each operation takes L+1 cycles, including the gap.
  - Outputs update and `update_pulse`=1 at edge T+1+4(L+1).
  - `ready` returns the same cycle.
- **Back-to-back:** a `start` held high through COMMIT is accepted on the first IDLE cycle.
- **Reset mid-operation:** abort immediately, clear all outputs, IDLE. A late `finish` after reset release is ignored in IDLE.
- **Single-cycle `start`:** sufficient.
- **Stuck multiplier:** a `finish` that never arrives stalls the FSM. There is no timeout.

## Structure
- Shared package `kf_pkg`:
  - `DBL_WIDTH`.
  - `FP64_HALF` and `FP64_SIXTH` constants.
  - FSM state enum `dtgen_state_t`.
  - Helper function `fp64_is_neg_or_nonfinite`.
- One sub-module instance: `fp_multiplier` (clk, valid, finish, a, b, result), operand-muxed by state.
- No other sub-modules.

## Test plan
- **dt_in=1.0:** `dt_in`=64'h3FF0000000000000 → `half_dt2`=64'h3FE0000000000000, `sixth_dt3`=64'h3FC5555555555555, `update_pulse` once at T+1+4(L+1), `params_valid`=1.
- **dt_in=2.0:** `dt_in`=64'h4000000000000000 → `delta_t`=64'h4000000000000000, `half_dt2`=64'h4000000000000000, `sixth_dt3`=64'h3FF5555555555555. All three change on the same edge.
- **Rejected start:** `dt_in`=64'hBFF0000000000000 (−1.0), then 64'h7FF8000000000000 (NaN) → `err_pulse` each time. Outputs and `params_valid` stay unchanged and `ready` stays 1.
- **Start while busy / outputs during computation:** after 1.0 published, start with 0.5. Pulse `start` with 2.0 mid-computation → ignored. Final `half_dt2`=64'h3FC0000000000000, `sixth_dt3`=64'h3F95555555555555. Old 1.0 set is visible until that commit.
- **Reset mid-operation:** assert `rst_n`=0 during MUL_DT3 → all outputs 0, `ready`=1, multiplier `valid`=0. A fresh start with 1.0 then produces correct values.
- **Variable multiplier latency:** bench model with L=1, then L=7 → `valid` held until `finish`, one-cycle gap observed between operations, results identical.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman-filter time-coefficient generator.
//   DBL_WIDTH               : operand width (IEEE-754 binary64 only)
//   FP64_HALF / FP64_SIXTH  : 0.5 and 1/6 (round-to-nearest) as binary64
//   dtgen_state_t           : sequencing FSM states of kf_dt_param_gen
//   fp64_is_neg_or_nonfinite: screen for an unusable sample interval
package kf_pkg;

    localparam int unsigned DBL_WIDTH = 64;

    localparam logic [DBL_WIDTH-1:0] FP64_HALF  = 64'h3FE0000000000000;
    localparam logic [DBL_WIDTH-1:0] FP64_SIXTH = 64'h3FC5555555555555;

    typedef enum logic [2:0] {
        StIdle,
        StMulDt2,
        StMulHalf,
        StMulDt3,
        StMulSixth,
        StCommit
    } dtgen_state_t;

    // Negative values (including -0.0), infinities and NaNs are not usable
    // as a sample interval. +0.0 and subnormals pass.
    function automatic logic fp64_is_neg_or_nonfinite(input logic [DBL_WIDTH-1:0] x);
        return x[63] | (x[62:52] == 11'h7FF);
    endfunction

endpackage

// File: rtl/kf_dt_param_gen_fpmul.sv
// fp_multiplier: binary64 multiplier, round-to-nearest-even, with a
// valid/finish handshake of configurable latency.
//   clk    : clock
//   valid  : operation request; a/b must stay stable while it is high
//   finish : result is valid; asserted in the Latency-th cycle of valid
//   a, b   : operands
//   result : product (combinational from a/b, meaningful with finish)
// The counter has no reset: it clears itself whenever valid is low.
module fp_multiplier
    import kf_pkg::*;
#(
    parameter int unsigned Latency = 3
) (
    input  logic                 clk,
    input  logic                 valid,
    output logic                 finish,
    input  logic [DBL_WIDTH-1:0] a,
    input  logic [DBL_WIDTH-1:0] b,
    output logic [DBL_WIDTH-1:0] result
);

    logic [7:0] cnt_q, cnt_d;

    assign finish = valid && (cnt_q == 8'(Latency - 1));

    always_comb begin
        cnt_d = 8'd0;
        if (valid && !finish) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    logic               sa, sb, s_res;
    logic [10:0]        ea, eb, ea_eff, eb_eff, exp_base;
    logic [51:0]        fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [52:0]        sig_a, sig_b, mant;
    logic [105:0]       prod, norm, shifted;
    logic [6:0]         lz;
    logic signed [13:0] exp_n;
    logic [13:0]        rsh;
    logic               lost, guard, sticky, rnd;
    logic [62:0]        mag;

    always_comb begin
        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        s_res  = sa ^ sb;
        a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
        b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
        a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
        b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
        a_zero = (ea == 11'd0) && (fa == 52'd0);
        b_zero = (eb == 11'd0) && (fb == 52'd0);

        // Subnormals use exponent 1 with no hidden bit.
        sig_a  = {ea != 11'd0, fa};
        sig_b  = {eb != 11'd0, fb};
        ea_eff = (ea == 11'd0) ? 11'd1 : ea;
        eb_eff = (eb == 11'd0) ? 11'd1 : eb;
        prod   = {53'd0, sig_a} * {53'd0, sig_b};

        lz = 7'd0;
        for (int i = 0; i < 106; i++) begin
            if (prod[i]) begin
                lz = 7'(105 - i);
            end
        end
        norm = prod << lz;

        // Biased exponent of the product once its leading one sits at bit 105.
        exp_n = $signed({3'b000, ea_eff}) + $signed({3'b000, eb_eff}) - 14'sd1022
              - $signed({7'd0, lz});

        // Underflow: denormalise before rounding so rounding happens once.
        rsh = 14'd0;
        if (exp_n < 14'sd1) begin
            rsh = 14'(14'sd1 - exp_n);
            if (rsh > 14'd107) begin
                rsh = 14'd107;
            end
        end
        shifted = norm >> rsh;
        lost    = |(norm & ~({106{1'b1}} << rsh));

        mant   = shifted[105:53];
        guard  = shifted[52];
        sticky = (|shifted[51:0]) | lost;
        rnd    = guard & (sticky | mant[0]);

        // Hidden bit of mant adds the final +1 to the exponent field; a rounding
        // carry out of the mantissa then bumps the exponent naturally.
        exp_base = (exp_n >= 14'sd1) ? (exp_n[10:0] - 11'd1) : 11'd0;
        mag      = {exp_base, 52'd0} + {10'd0, mant} + {62'd0, rnd};

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result = 64'h7FF8000000000000;
        end else if (a_inf || b_inf) begin
            result = {s_res, 11'h7FF, 52'd0};
        end else if (a_zero || b_zero) begin
            result = {s_res, 63'd0};
        end else if (exp_n > 14'sd2046) begin
            result = {s_res, 11'h7FF, 52'd0};
        end else begin
            result = {s_res, mag};
        end
    end

endmodule

// File: rtl/kf_dt_param_gen.sv
// kf_dt_param_gen: computes the CMU time coefficients dt, dt^2/2 and dt^3/6
// from a new sample interval using one shared fp_multiplier, and publishes
// them atomically.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, dt_in : request + new dt (binary64), taken when ready
//   ready        : FSM idle
//   delta_t, half_dt2, sixth_dt3 : published coefficient set
//   params_valid : published set is valid (never withdrawn except by reset)
//   update_pulse : one cycle, a new set has just been published
//   err_pulse    : one cycle, a start was rejected (negative / Inf / NaN)
module kf_dt_param_gen
    import kf_pkg::*;
#(
    parameter logic [DBL_WIDTH-1:0] HALF_CONST  = FP64_HALF,
    parameter logic [DBL_WIDTH-1:0] SIXTH_CONST = FP64_SIXTH,
    parameter int unsigned          MulLatency  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DBL_WIDTH-1:0] dt_in,
    output logic                 ready,
    output logic [DBL_WIDTH-1:0] delta_t,
    output logic [DBL_WIDTH-1:0] half_dt2,
    output logic [DBL_WIDTH-1:0] sixth_dt3,
    output logic                 params_valid,
    output logic                 update_pulse,
    output logic                 err_pulse
);

    dtgen_state_t state_q, state_d;
    logic         gap_q, gap_d;   // one idle multiplier cycle after each result

    logic [DBL_WIDTH-1:0] dt_q, dt_d, dt2_q, dt2_d, half_q, half_d;
    logic [DBL_WIDTH-1:0] dt3_q, dt3_d, sixth_q, sixth_d;
    logic [DBL_WIDTH-1:0] pub_dt_q, pub_dt_d, pub_half_q, pub_half_d;
    logic [DBL_WIDTH-1:0] pub_sixth_q, pub_sixth_d;
    logic                 pub_valid_q, pub_valid_d, upd_q, upd_d, err_q, err_d;

    logic                 mul_valid, mul_finish;
    logic [DBL_WIDTH-1:0] mul_a, mul_b, mul_result;

    fp_multiplier #(
        .Latency(MulLatency)
    ) u_fp_multiplier (
        .clk   (clk),
        .valid (mul_valid),
        .finish(mul_finish),
        .a     (mul_a),
        .b     (mul_b),
        .result(mul_result)
    );

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        dt_d        = dt_q;
        dt2_d       = dt2_q;
        half_d      = half_q;
        dt3_d       = dt3_q;
        sixth_d     = sixth_q;
        pub_dt_d    = pub_dt_q;
        pub_half_d  = pub_half_q;
        pub_sixth_d = pub_sixth_q;
        pub_valid_d = pub_valid_q;
        upd_d       = 1'b0;
        err_d       = 1'b0;
        mul_valid   = 1'b0;
        mul_a       = dt_q;
        mul_b       = dt_q;

        // Operands are a pure function of state, so they stay stable for the
        // whole request and its gap cycle.
        unique case (state_q)
            StMulHalf: begin
                mul_a = dt2_q;
                mul_b = HALF_CONST;
            end
            StMulDt3: begin
                mul_a = dt2_q;
                mul_b = dt_q;
            end
            StMulSixth: begin
                mul_a = dt3_q;
                mul_b = SIXTH_CONST;
            end
            default: ;
        endcase

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (fp64_is_neg_or_nonfinite(dt_in)) begin
                        err_d = 1'b1;
                    end else begin
                        dt_d    = dt_in;
                        gap_d   = 1'b0;
                        state_d = StMulDt2;
                    end
                end
            end
            StMulDt2, StMulHalf, StMulDt3, StMulSixth: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                    unique case (state_q)
                        StMulDt2:  state_d = StMulHalf;
                        StMulHalf: state_d = StMulDt3;
                        StMulDt3:  state_d = StMulSixth;
                        default:   state_d = StCommit;
                    endcase
                end else begin
                    mul_valid = 1'b1;
                    if (mul_finish) begin
                        gap_d = 1'b1;
                        unique case (state_q)
                            StMulDt2:  dt2_d   = mul_result;
                            StMulHalf: half_d  = mul_result;
                            StMulDt3:  dt3_d   = mul_result;
                            default:   sixth_d = mul_result;
                        endcase
                    end
                end
            end
            StCommit: begin
                pub_dt_d    = dt_q;
                pub_half_d  = half_q;
                pub_sixth_d = sixth_q;
                pub_valid_d = 1'b1;
                upd_d       = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gap_q       <= 1'b0;
            dt_q        <= '0;
            dt2_q       <= '0;
            half_q      <= '0;
            dt3_q       <= '0;
            sixth_q     <= '0;
            pub_dt_q    <= '0;
            pub_half_q  <= '0;
            pub_sixth_q <= '0;
            pub_valid_q <= 1'b0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            dt_q        <= dt_d;
            dt2_q       <= dt2_d;
            half_q      <= half_d;
            dt3_q       <= dt3_d;
            sixth_q     <= sixth_d;
            pub_dt_q    <= pub_dt_d;
            pub_half_q  <= pub_half_d;
            pub_sixth_q <= pub_sixth_d;
            pub_valid_q <= pub_valid_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
        end
    end

    assign ready        = (state_q == StIdle);
    assign delta_t      = pub_dt_q;
    assign half_dt2     = pub_half_q;
    assign sixth_dt3    = pub_sixth_q;
    assign params_valid = pub_valid_q;
    assign update_pulse = upd_q;
    assign err_pulse    = err_q;

endmodule
